// File: rtl/sump_pkg.sv
// sump_pkg
// Shared definitions for the SUMP host-side command initiator: opcode
// constants, the controller state encoding and the command frame-length rule.
package sump_pkg;

    localparam logic [7:0] OP_RESET          = 8'h00;
    localparam logic [7:0] OP_ARM            = 8'h01;
    localparam logic [7:0] OP_ID             = 8'h02;
    localparam logic [7:0] OP_SET_DIVIDER    = 8'h80;
    localparam logic [7:0] OP_SET_TRIG_MASK  = 8'hC0;
    localparam logic [7:0] OP_SET_TRIG_VALUE = 8'hC1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_RECV,
        ST_FINISH
    } state_t;

    // Long commands (bit7 set) carry a 32-bit argument. RESET is also sent
    // as five bytes so a device stuck mid-long-command is flushed.
    function automatic logic [2:0] frame_len(input logic [7:0] op);
        return (op[7] || (op == OP_RESET)) ? 3'd5 : 3'd1;
    endfunction

endpackage

// File: rtl/sump_idle_timer.sv
// sump_idle_timer
// Receive-inactivity timer. Down-counter reloaded on clr, decremented while
// tick is high, saturating at zero; expired is the terminal-count compare.
// Ports:
//   cap_clk  - clock
//   rst_n    - asynchronous active-low reset
//   clr      - reload the counter (command accept, every received byte)
//   tick     - count enable (receive phase only)
//   expired  - counter has reached terminal count
module sump_idle_timer #(
    parameter int unsigned IDLE_TIMEOUT = 83_400
) (
    input  logic cap_clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    localparam int CW = $clog2(IDLE_TIMEOUT);
    // Two cycles are consumed after terminal count (the FINISH state and the
    // registered DONE), so loading IDLE_TIMEOUT-2 lands DONE exactly
    // IDLE_TIMEOUT cycles after the last received byte.
    localparam logic [CW-1:0] LOAD_VAL = CW'(IDLE_TIMEOUT - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge cap_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= LOAD_VAL;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/sump_host_initiator.sv
// sump_host_initiator
// Sends one SUMP command frame byte-by-byte to a UART transmitter, then
// collects the expected response (ARM: sample block, ID: metadata string),
// streaming each received byte out with its index.
// Ports:
//   cap_clk, rst_n                  - clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_op/cmd_arg - command handshake and payload
//   tx_data/tx_start/tx_busy        - UART transmit side
//   rx_ready/rx_data                - UART receive side
//   smp_valid/smp_data/smp_index    - received response byte stream
//   rx_count                        - bytes received in current/last response
//   done/timeout                    - end-of-transaction strobes
//   busy                            - inverse of cmd_ready
//
// state     | meaning
// ST_IDLE   | waiting for a command
// ST_LOAD   | present next frame byte, strobe when UART is free
// ST_WAIT_HI| wait for UART to take the byte (busy rises)
// ST_WAIT_LO| wait for UART to finish the byte (busy falls)
// ST_RECV   | collect response bytes until count/terminator/idle timeout
// ST_FINISH | issue DONE (and TIMEOUT if abandoned)
module sump_host_initiator
    import sump_pkg::*;
#(
    parameter int unsigned SAMPLE_DEPTH = 8192,
    parameter int unsigned ID_MAX_BYTES = 32,
    parameter int unsigned IDLE_TIMEOUT = 83_400
) (
    input  logic        cap_clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        smp_valid,
    output logic [7:0]  smp_data,
    output logic [12:0] smp_index,
    output logic [13:0] rx_count,
    output logic        done,
    output logic        timeout,
    output logic        busy
);

    localparam logic [13:0] ARM_LEN     = 14'(SAMPLE_DEPTH);
    localparam logic [13:0] ID_LEN      = 14'(ID_MAX_BYTES);
    localparam logic [13:0] ID_MIN_ZERO = 14'd16;

    state_t      state;
    logic [7:0]  op_q;
    logic [31:0] arg_q;
    logic [2:0]  byte_idx;
    logic        to_flag;
    logic        expired;
    logic        timer_clr;
    logic [7:0]  frame_byte;
    logic [13:0] rx_next;
    logic        rx_last;

    assign timer_clr = ((state == ST_IDLE) && cmd_valid) ||
                       ((state == ST_RECV) && rx_ready);

    sump_idle_timer #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_idle_timer (
        .cap_clk (cap_clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .tick    (state == ST_RECV),
        .expired (expired)
    );

    always_comb begin
        frame_byte = op_q;
        case (byte_idx)
            3'd1:    frame_byte = arg_q[7:0];
            3'd2:    frame_byte = arg_q[15:8];
            3'd3:    frame_byte = arg_q[23:16];
            3'd4:    frame_byte = arg_q[31:24];
            default: frame_byte = op_q;
        endcase
        if (op_q == OP_RESET) frame_byte = 8'h00;
    end

    // ID terminator: first 0x00 at index >= 16, else the byte cap.
    always_comb begin
        rx_next = rx_count + 14'd1;
        rx_last = ((op_q == OP_ARM) && (rx_next == ARM_LEN)) ||
                  ((op_q == OP_ID) && ((rx_next == ID_LEN) ||
                   ((rx_data == 8'h00) && (rx_count >= ID_MIN_ZERO))));
    end

    always_ff @(posedge cap_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            arg_q     <= '0;
            byte_idx  <= '0;
            to_flag   <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            smp_valid <= 1'b0;
            smp_data  <= '0;
            smp_index <= '0;
            rx_count  <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            smp_valid <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        arg_q    <= cmd_arg;
                        byte_idx <= '0;
                        rx_count <= '0;
                        to_flag  <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_data <= frame_byte;
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (tx_busy) state <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        if ((byte_idx + 3'd1) < frame_len(op_q)) begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= ST_LOAD;
                        end else if ((op_q == OP_ARM) || (op_q == OP_ID)) begin
                            state <= ST_RECV;
                        end else begin
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_RECV: begin
                    if (rx_ready) begin
                        smp_valid <= 1'b1;
                        smp_data  <= rx_data;
                        smp_index <= rx_count[12:0];
                        rx_count  <= rx_next;
                        if (rx_last) state <= ST_FINISH;
                    end
                    // A byte arriving on the expiry cycle is still emitted above.
                    if (expired) begin
                        to_flag <= 1'b1;
                        state   <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done    <= 1'b1;
                    timeout <= to_flag;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = ~cmd_ready;

endmodule

// File: doc/sump_host_initiator.md
SUMP_HOST_INITIATOR -- requirements
Module: sump_host_initiator

Interface
REQ-001 Parameter SAMPLE_DEPTH, default 8192: sample bytes expected after an ARM command.
REQ-002 Parameter ID_MAX_BYTES, default 32: byte cap for an ID response.
REQ-003 Parameter IDLE_TIMEOUT, default 83_400: CAP_CLK cycles without an RX byte before a receive is abandoned (about 20 byte-times at 48 MHz / 115200).
REQ-004 CAP_CLK in 1: the single clock; all logic is on its rising edge.
REQ-005 RST_N in 1: asynchronous, active-low reset.
REQ-006 CMD_VALID in 1: command request present.
REQ-007 CMD_READY out 1: block is idle and accepts a command.
REQ-008 CMD_OP in 8: SUMP opcode.
REQ-009 CMD_ARG in 32: argument for long commands.
REQ-010 TX_DATA out 8: byte to the UART transmitter.
REQ-011 TX_START out 1: one-cycle send strobe.
REQ-012 TX_BUSY in 1: UART transmitter busy.
REQ-013 RX_READY in 1: one-cycle received-byte strobe.
REQ-014 RX_DATA in 8: received byte.
REQ-015 SMP_VALID out 1: one-cycle strobe; SMP_DATA/SMP_INDEX are valid.
REQ-016 SMP_DATA out 8: received response byte.
REQ-017 SMP_INDEX out 13: position of the byte in the response, from 0.
REQ-018 RX_COUNT out 14: bytes received in the current or last response.
REQ-019 DONE out 1: one-cycle strobe at the end of a transaction.
REQ-020 TIMEOUT out 1: one-cycle strobe, asserted together with DONE when a receive is abandoned.
REQ-021 BUSY out 1: equals NOT CMD_READY.

Function
REQ-022 A command is accepted in the cycle where CMD_VALID and CMD_READY are both high; CMD_OP and CMD_ARG are captured then. CMD_VALID is ignored while BUSY.
REQ-023 Frame length: opcode bit7 = 1 gives 5 bytes (opcode, then ARG[7:0], [15:8], [23:16], [31:24]); bit7 = 0 gives 1 byte.
REQ-024 Opcode 0x00 (RESET) is sent as five 0x00 bytes.
REQ-025 States: IDLE, LOAD, WAIT_HI, WAIT_LO, RECV, FINISH.
- IDLE -> LOAD on accept.
- LOAD drives TX_DATA and pulses TX_START once only if TX_BUSY = 0; otherwise it stays in LOAD.
- WAIT_HI waits for TX_BUSY = 1. WAIT_LO waits for TX_BUSY = 0.
- After WAIT_LO: go to LOAD if frame bytes remain, else to RECV or FINISH per REQ-026.
- FINISH pulses DONE for one cycle and returns to IDLE.
REQ-026 Response expectation:
- ARM (0x01) expects SAMPLE_DEPTH bytes.
- ID (0x02) expects bytes until 0x00 is received at an even-keyed position after 0x20+ key payloads, or ID_MAX_BYTES bytes, whichever comes first. The simplified rule applies: stop at the first 0x00 received after index >= 16, or at ID_MAX_BYTES.
- All other opcodes expect no response and go directly to FINISH.
REQ-027 In RECV, each RX_READY produces SMP_VALID in the next cycle, with SMP_DATA = RX_DATA and SMP_INDEX = the pre-increment RX_COUNT; RX_COUNT then increments.
- Latency from RX_READY to SMP_VALID is exactly 1 cycle.
REQ-028 On the byte that completes the expected count, the block goes to FINISH in the same cycle SMP_VALID rises. DONE follows one cycle later with TIMEOUT = 0.
REQ-029 The idle counter clears on accept and on every RX_READY in RECV.
- It reaching IDLE_TIMEOUT causes FINISH with TIMEOUT = 1.
- RX_COUNT holds the partial count.
REQ-030 RX_READY outside RECV is discarded: no SMP_VALID and no count change.
REQ-031 RX_READY arriving in the same cycle as the timeout expiry is counted and emitted; the timeout then still terminates the transaction.
REQ-032 RX_COUNT clears on accept and otherwise holds until the next accept. SMP_INDEX does not wrap within SAMPLE_DEPTH <= 8192.
REQ-033 TX_BUSY already high when LOAD is entered delays the strobe; it never causes a byte to be skipped.

Reset
REQ-034 RST_N low asynchronously forces state IDLE and zeroes every output, counter and captured register, except CMD_READY = 1 and BUSY = 0.
REQ-035 Reset mid-frame or mid-receive abandons the transaction with no DONE. The first edge after release is in IDLE.

Structure
REQ-036 A shared package sump_pkg holds:
- opcode constants 0x00, 0x01, 0x02, 0x80, 0xC0, 0xC1;
- the state enum;
- the frame-length function.
REQ-037 One sub-module, sump_idle_timer (clear, tick-enable, expired), implements REQ-029. All other logic stays in sump_host_initiator.

Verification
REQ-038 CMD_OP = 0x80, CMD_ARG = 0x00000063, UART model busy for 10 cycles per byte -> TX bytes 80 63 00 00 00, then DONE with TIMEOUT = 0 and RX_COUNT = 0.
REQ-039 CMD_OP = 0x01, model returns 8192 bytes with value i & 0xFF -> 8192 SMP_VALID pulses with matching SMP_DATA and SMP_INDEX 0..8191, then one DONE with RX_COUNT = 8192.
REQ-040 CMD_OP = 0x01, model returns 100 bytes then stops -> DONE and TIMEOUT exactly IDLE_TIMEOUT cycles after the 100th RX_READY, with RX_COUNT = 100.
REQ-041 CMD_OP = 0x00 -> five 0x00 TX bytes, with no receive phase.
REQ-042 CMD_OP = 0x02, model returns the 32-byte metadata string ending in 0x00 at index 31 -> DONE after 32 bytes. A CMD_VALID pulsed during this transaction is not accepted.
REQ-043 RST_N pulsed low during the byte-4000 receive of an ARM -> all outputs return to reset values immediately, no DONE, and a following 0x02 command completes normally.
